// File: rtl/rx_buffer_if.sv
// Bus bundle between the UART receiver / CPU side and the receive frame buffer.
// The master drives bytes, reads and clears; the slave (rx_buffer) reports data and status.
interface rx_buffer_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
);
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rd;
    logic [AW-1:0]     address;
    logic              clr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              full;
    logic [AW:0]       count;
    logic              overrun;

    modport master (
        output rx_done, rx_data, rd, address, clr,
        input  r_data, r_valid, full, count, overrun
    );

    modport slave (
        input  rx_done, rx_data, rd, address, clr,
        output r_data, r_valid, full, count, overrun
    );
endinterface

// File: rtl/rx_buffer.sv
// Receive-side frame buffer: collects DEPTH bytes from the UART receiver, flags a ready
// frame with full, serves registered CPU reads by address, and is released by clr.
module rx_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input logic        clk,
    input logic        rst_n,
    rx_buffer_if.slave bus
);
    typedef enum logic {FILL, FULL} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t            state, state_next;
    logic [AW-1:0]     w_ptr, w_ptr_next;
    logic [AW:0]       count, count_next;
    logic              overrun, overrun_next;
    logic              full;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next   = state;
        w_ptr_next   = w_ptr;
        count_next   = count;
        overrun_next = overrun;
        wr_en        = 1'b0;
        wr_addr      = w_ptr;
        if (bus.clr) begin
            // Clear wins, but a byte arriving on the same edge still lands at entry 0.
            state_next   = FILL;
            w_ptr_next   = '0;
            count_next   = '0;
            overrun_next = 1'b0;
            if (bus.rx_done) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                w_ptr_next = AW'(1);
                count_next = (AW+1)'(1);
            end
        end else begin
            case (state)
                FILL: begin
                    if (bus.rx_done) begin
                        wr_en      = 1'b1;
                        w_ptr_next = w_ptr + AW'(1);
                        count_next = count + (AW+1)'(1);
                        if (count_next == DEPTH_C) state_next = FULL;
                    end
                end
                FULL: begin
                    if (bus.rx_done) overrun_next = 1'b1;
                end
                default: state_next = FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so reads below see pre-edge count and contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            count   <= '0;
            overrun <= 1'b0;
            full    <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            // NOTE: the entries are reset too, so a read of any slot after reset is deterministic.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            w_ptr   <= w_ptr_next;
            count   <= count_next;
            overrun <= overrun_next;
            full    <= (state_next == FULL);
            r_valid <= bus.rd;
            if (bus.rd) begin
                if ({1'b0, bus.address} < count) r_data <= mem[bus.address];
                else                             r_data <= '0;
            end
            if (wr_en) mem[wr_addr] <= bus.rx_data;
        end
    end

    assign bus.r_data  = r_data;
    assign bus.r_valid = r_valid;
    assign bus.full    = full;
    assign bus.count   = count;
    assign bus.overrun = overrun;
endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: table-driven cycles with a read-data scoreboard,
// plus a hand-written asynchronous reset sequence.
module tb_rx_buffer;
    localparam int DATA_W = 8;
    localparam int AW     = 2;

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       rd;
        logic [1:0] address;
        logic       clr;
        logic [2:0] e_count;
        logic       e_full;
        logic       e_overrun;
        logic [7:0] e_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] sb_q [$];

    rx_buffer_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    rx_buffer #(.DEPTH(4), .DATA_W(DATA_W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rx_done = v.rx_done;
        bus.rx_data = v.rx_data;
        bus.rd      = v.rd;
        bus.address = v.address;
        bus.clr     = v.clr;
    endtask

    // One clock cycle: drive, push expected read data, sample #1 after the edge.
    task automatic step(input vec_t v, input string name);
        logic [7:0] exp_rd;
        drive(v);
        if (v.rd) sb_q.push_back(v.e_rdata);
        @(posedge clk);
        #1;
        check({name, " count"},   32'(bus.count),   32'(v.e_count));
        check({name, " full"},    32'(bus.full),    32'(v.e_full));
        check({name, " overrun"}, 32'(bus.overrun), 32'(v.e_overrun));
        check({name, " r_valid"}, 32'(bus.r_valid), 32'(v.rd));
        if (bus.r_valid) begin
            if (sb_q.size() == 0) begin
                check({name, " r_valid without pending read"}, 32'(1), 32'(0));
            end else begin
                exp_rd = sb_q.pop_front();
                check({name, " r_data"}, 32'(bus.r_data), 32'(exp_rd));
            end
        end
        bus.rx_done = 1'b0;
        bus.rd      = 1'b0;
        bus.clr     = 1'b0;
    endtask

    function automatic vec_t mk(input logic rxd, input logic [7:0] d, input logic rd,
                                input logic [1:0] a, input logic clr, input logic [2:0] c,
                                input logic f, input logic o, input logic [7:0] rdat);
        vec_t v;
        v.rx_done = rxd; v.rx_data = d; v.rd = rd; v.address = a; v.clr = clr;
        v.e_count = c; v.e_full = f; v.e_overrun = o; v.e_rdata = rdat;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        drive(mk(0, 8'h00, 0, 2'd0, 0, 0, 0, 0, 8'h00));
        #2;
        check("reset count",   32'(bus.count),   32'(0));
        check("reset full",    32'(bus.full),    32'(0));
        check("reset overrun", 32'(bus.overrun), 32'(0));
        check("reset r_valid", 32'(bus.r_valid), 32'(0));
        check("reset r_data",  32'(bus.r_data),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        //            rxd data   rd addr clr cnt full ovr rdata
        tbl.push_back(mk(0, 8'h00, 1, 2'd0, 0, 0, 0, 0, 8'h00)); // read with nothing stored
        tbl.push_back(mk(1, 8'h41, 0, 2'd0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h42, 0, 2'd0, 0, 2, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h43, 0, 2'd0, 0, 3, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h44, 0, 2'd0, 0, 4, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 2'd0, 0, 4, 1, 0, 8'h41));
        tbl.push_back(mk(0, 8'h00, 1, 2'd1, 0, 4, 1, 0, 8'h42));
        tbl.push_back(mk(0, 8'h00, 1, 2'd2, 0, 4, 1, 0, 8'h43));
        tbl.push_back(mk(0, 8'h00, 1, 2'd3, 0, 4, 1, 0, 8'h44));
        tbl.push_back(mk(0, 8'h00, 1, 2'd1, 0, 4, 1, 0, 8'h42)); // re-read
        tbl.push_back(mk(1, 8'h55, 0, 2'd0, 0, 4, 1, 1, 8'h00)); // overrun
        tbl.push_back(mk(0, 8'h00, 1, 2'd0, 0, 4, 1, 1, 8'h41));
        tbl.push_back(mk(0, 8'h00, 1, 2'd3, 1, 0, 0, 0, 8'h44)); // rd+clr: pre-clear view
        tbl.push_back(mk(0, 8'h00, 1, 2'd0, 0, 0, 0, 0, 8'h00)); // retained but count=0
        tbl.push_back(mk(1, 8'h10, 0, 2'd0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h20, 0, 2'd0, 0, 2, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 2'd3, 0, 2, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 2'd1, 0, 2, 0, 0, 8'h20));
        tbl.push_back(mk(1, 8'h30, 1, 2'd2, 0, 3, 0, 0, 8'h00)); // rd+write same slot, pre-write count
        tbl.push_back(mk(0, 8'h00, 1, 2'd2, 0, 3, 0, 0, 8'h30));
        tbl.push_back(mk(1, 8'h40, 0, 2'd0, 0, 4, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'hAA, 0, 2'd0, 0, 4, 1, 1, 8'h00));
        tbl.push_back(mk(1, 8'h99, 0, 2'd0, 1, 1, 0, 0, 8'h00)); // clr+rx while full
        tbl.push_back(mk(0, 8'h00, 1, 2'd0, 0, 1, 0, 0, 8'h99));
        tbl.push_back(mk(1, 8'h11, 1, 2'd1, 0, 2, 0, 0, 8'h00)); // write entry 1, read uses old count
        tbl.push_back(mk(0, 8'h00, 1, 2'd1, 0, 2, 0, 0, 8'h11));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a partially stored frame.
        step(mk(0, 8'h00, 0, 2'd0, 1, 0, 0, 0, 8'h00), "ar clr");
        step(mk(1, 8'h01, 0, 2'd0, 0, 1, 0, 0, 8'h00), "ar b0");
        step(mk(1, 8'h02, 0, 2'd0, 0, 2, 0, 0, 8'h00), "ar b1");
        step(mk(1, 8'h03, 1, 2'd1, 0, 3, 0, 0, 8'h02), "ar b2");
        #2;
        rst_n = 1'b0;
        #1;
        check("async count",   32'(bus.count),   32'(0));
        check("async full",    32'(bus.full),    32'(0));
        check("async overrun", 32'(bus.overrun), 32'(0));
        check("async r_data",  32'(bus.r_data),  32'(0));
        check("async r_valid", 32'(bus.r_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 8'h77, 0, 2'd0, 0, 1, 0, 0, 8'h00), "post-reset byte");
        step(mk(0, 8'h00, 1, 2'd0, 0, 1, 0, 0, 8'h77), "post-reset rd0");
        step(mk(0, 8'h00, 1, 2'd1, 0, 1, 0, 0, 8'h00), "post-reset rd1");
        step(mk(0, 8'h00, 0, 2'd0, 0, 1, 0, 0, 8'h00), "idle");

        check("scoreboard drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
